// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl
//   Turns single-cycle button pulses into run/clear controls for the stopwatch counter core.
//   Captures lap times into a circular buffer and offers a review mode that walks the stored
//   laps from oldest to newest. Every output is registered, so a pulse sampled at one edge
//   is visible on the outputs right after that edge.
//
// Ports
//   clk_core    system clock
//   rst         asynchronous active-low reset
//   start_stop  pulse: run/stop toggle, also leaves review
//   lap_rst     pulse: capture a lap while running, full clear while stopped
//   review      pulse: enter review / step to the next lap
//   min_i       live minutes (BCD)
//   sec_i       live seconds (BCD)
//   ms_10_i     live 10 ms units (BCD)
//   cnt_en      counter core enable, high only while running
//   cnt_clr     one-cycle synchronous clear for the counter core
//   min_o       displayed minutes
//   sec_o       displayed seconds
//   ms_10_o     displayed 10 ms units
//   lap_cnt     number of valid laps, 0..DEPTH
//   lap_idx     review index, 0 = oldest stored lap
//   reviewing   high while in review mode
module stopwatch_lap_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk_core,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             lap_rst,
  input  logic             review,
  input  logic [7:0]       min_i,
  input  logic [7:0]       sec_i,
  input  logic [7:0]       ms_10_i,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [7:0]       min_o,
  output logic [7:0]       sec_o,
  output logic [7:0]       ms_10_o,
  output logic [IDX_W:0]   lap_cnt,
  output logic [IDX_W-1:0] lap_idx,
  output logic             reviewing
);

  localparam logic [IDX_W:0]   LapMax = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   CntOne = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] PtrOne = IDX_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StReview} state_e;

  state_e           state_q, state_d;
  logic             ret_stop_q, ret_stop_d;  // 1: leave review to STOP, 0: to IDLE
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   lap_cnt_d;
  logic [IDX_W-1:0] lap_idx_d;
  logic             cnt_clr_d;
  logic             lap_we;
  logic             last_lap;
  logic [IDX_W-1:0] rd_addr;
  logic [23:0]      disp_d;

  logic [23:0]      lap_buf [DEPTH];

  assign last_lap = ({1'b0, lap_idx} == (lap_cnt - CntOne));

  always_comb begin
    state_d    = state_q;
    ret_stop_d = ret_stop_q;
    wr_ptr_d   = wr_ptr_q;
    lap_cnt_d  = lap_cnt;
    lap_idx_d  = lap_idx;
    cnt_clr_d  = 1'b0;
    lap_we     = 1'b0;
    // Branch order encodes the pulse priority start_stop > lap_rst > review.
    unique case (state_q)
      StIdle: begin
        if (start_stop) begin
          state_d = StRun;
        end else if (review && (lap_cnt != '0)) begin
          state_d    = StReview;
          ret_stop_d = 1'b0;
          lap_idx_d  = '0;
        end
      end
      StRun: begin
        if (start_stop) begin
          state_d = StStop;
        end else if (lap_rst) begin
          lap_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          if (lap_cnt != LapMax) begin
            lap_cnt_d = lap_cnt + CntOne;
          end
        end
      end
      StStop: begin
        if (start_stop) begin
          state_d = StRun;
        end else if (lap_rst) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          lap_cnt_d = '0;
          wr_ptr_d  = '0;
        end else if (review && (lap_cnt != '0)) begin
          state_d    = StReview;
          ret_stop_d = 1'b1;
          lap_idx_d  = '0;
        end
      end
      StReview: begin
        if (start_stop) begin
          state_d   = ret_stop_q ? StStop : StIdle;
          lap_idx_d = '0;
        end else if (review) begin
          if (last_lap) begin
            state_d   = ret_stop_q ? StStop : StIdle;
            lap_idx_d = '0;
          end else begin
            lap_idx_d = lap_idx + PtrOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign rd_addr = (lap_cnt_d == LapMax) ? (wr_ptr_d + lap_idx_d) : lap_idx_d;

  // Display follows the next state so a review step and its lap data appear together.
  assign disp_d = (state_d == StReview) ? lap_buf[rd_addr] : {min_i, sec_i, ms_10_i};

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ret_stop_q <= 1'b0;
      wr_ptr_q   <= '0;
      lap_cnt    <= '0;
      lap_idx    <= '0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      reviewing  <= 1'b0;
      min_o      <= '0;
      sec_o      <= '0;
      ms_10_o    <= '0;
    end else begin
      state_q    <= state_d;
      ret_stop_q <= ret_stop_d;
      wr_ptr_q   <= wr_ptr_d;
      lap_cnt    <= lap_cnt_d;
      lap_idx    <= lap_idx_d;
      cnt_en     <= (state_d == StRun);
      cnt_clr    <= cnt_clr_d;
      reviewing  <= (state_d == StReview);
      {min_o, sec_o, ms_10_o} <= disp_d;
    end
  end

  // Lap storage carries no reset; entries beyond lap_cnt are never shown.
  always_ff @(posedge clk_core) begin
    if (lap_we) begin
      lap_buf[wr_ptr_q] <= {min_i, sec_i, ms_10_i};
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
module tb_stopwatch_lap_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;

  logic             clk_core = 1'b0;
  logic             rst = 1'b0;
  logic             start_stop = 1'b0;
  logic             lap_rst = 1'b0;
  logic             review = 1'b0;
  logic [7:0]       min_i = '0;
  logic [7:0]       sec_i = '0;
  logic [7:0]       ms_10_i = '0;
  logic             cnt_en;
  logic             cnt_clr;
  logic [7:0]       min_o;
  logic [7:0]       sec_o;
  logic [7:0]       ms_10_o;
  logic [IDX_W:0]   lap_cnt;
  logic [IDX_W-1:0] lap_idx;
  logic             reviewing;

  stopwatch_lap_ctrl #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) dut (
    .clk_core  (clk_core),
    .rst       (rst),
    .start_stop(start_stop),
    .lap_rst   (lap_rst),
    .review    (review),
    .min_i     (min_i),
    .sec_i     (sec_i),
    .ms_10_i   (ms_10_i),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .min_o     (min_o),
    .sec_o     (sec_o),
    .ms_10_o   (ms_10_o),
    .lap_cnt   (lap_cnt),
    .lap_idx   (lap_idx),
    .reviewing (reviewing)
  );

  always #5 clk_core = ~clk_core;

  // Vector layout: {cnt_en, cnt_clr, reviewing, lap_cnt[3:0], lap_idx[2:0], min, sec, ms_10}
  typedef struct {
    string       tag;
    logic [33:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] lap_model[$];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [33:0] mk(input logic en, input logic clr, input logic rv,
                                     input logic [3:0] cnt, input logic [2:0] idx,
                                     input logic [23:0] disp);
    return {en, clr, rv, cnt, idx, disp};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = 8'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  task automatic compare();
    exp_t        e;
    logic [33:0] obs;
    e   = sb.pop_front();
    obs = {cnt_en, cnt_clr, reviewing, lap_cnt, lap_idx, min_o, sec_o, ms_10_o};
    checks++;
    assert (obs === e.exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [33:0] e);
    sb.push_back('{tag: tag, exp: e});
    compare();
  endtask

  // Drive one cycle of pulses and live inputs, then compare just after the edge.
  task automatic step(input logic ss, input logic lr, input logic rv, input logic [23:0] live,
                      input string tag, input logic [33:0] e);
    @(negedge clk_core);
    start_stop = ss;
    lap_rst    = lr;
    review     = rv;
    {min_i, sec_i, ms_10_i} = live;
    sb.push_back('{tag: tag, exp: e});
    @(posedge clk_core);
    #1;
    start_stop = 1'b0;
    lap_rst    = 1'b0;
    review     = 1'b0;
    compare();
  endtask

  initial begin
    logic [23:0] live;
    #1;
    chk_now("reset", mk(0, 0, 0, 4'd0, 3'd0, 24'h0));
    @(negedge clk_core);
    rst = 1'b1;

    // Start and live pass-through
    step(1, 0, 0, 24'h012345, "start", mk(1, 0, 0, 4'd0, 3'd0, 24'h012345));
    step(0, 0, 0, 24'h012346, "run_live", mk(1, 0, 0, 4'd0, 3'd0, 24'h012346));

    // Three laps, stop, review all, wrap back to STOP
    step(0, 1, 0, 24'h000100, "lap1", mk(1, 0, 0, 4'd1, 3'd0, 24'h000100));
    step(0, 1, 0, 24'h000250, "lap2", mk(1, 0, 0, 4'd2, 3'd0, 24'h000250));
    step(0, 1, 0, 24'h000375, "lap3", mk(1, 0, 0, 4'd3, 3'd0, 24'h000375));
    step(1, 0, 0, 24'h000400, "stop", mk(0, 0, 0, 4'd3, 3'd0, 24'h000400));
    step(0, 0, 1, 24'h000400, "rev0", mk(0, 0, 1, 4'd3, 3'd0, 24'h000100));
    step(0, 0, 1, 24'h000400, "rev1", mk(0, 0, 1, 4'd3, 3'd1, 24'h000250));
    step(0, 0, 1, 24'h000400, "rev2", mk(0, 0, 1, 4'd3, 3'd2, 24'h000375));
    step(0, 0, 1, 24'h000400, "rev_exit", mk(0, 0, 0, 4'd3, 3'd0, 24'h000400));
    step(0, 1, 1, 24'h000400, "lr_wins_rev", mk(0, 1, 0, 4'd0, 3'd0, 24'h000400));
    step(0, 0, 0, 24'h000400, "idle_again", mk(0, 0, 0, 4'd0, 3'd0, 24'h000400));

    // Priority checks
    step(1, 0, 0, 24'h000500, "run2", mk(1, 0, 0, 4'd0, 3'd0, 24'h000500));
    step(0, 1, 0, 24'h000600, "lap_a", mk(1, 0, 0, 4'd1, 3'd0, 24'h000600));
    step(1, 1, 0, 24'h000700, "ss_lr_run", mk(0, 0, 0, 4'd1, 3'd0, 24'h000700));
    step(1, 0, 1, 24'h000800, "ss_rv_stop", mk(1, 0, 0, 4'd1, 3'd0, 24'h000800));
    step(0, 0, 1, 24'h000900, "rv_in_run", mk(1, 0, 0, 4'd1, 3'd0, 24'h000900));
    step(1, 0, 0, 24'h001000, "stop2", mk(0, 0, 0, 4'd1, 3'd0, 24'h001000));
    step(0, 0, 1, 24'h001000, "rev_enter", mk(0, 0, 1, 4'd1, 3'd0, 24'h000600));
    step(0, 1, 0, 24'h001000, "lr_in_rev", mk(0, 0, 1, 4'd1, 3'd0, 24'h000600));
    step(1, 0, 0, 24'h001100, "ss_exit_rev", mk(0, 0, 0, 4'd1, 3'd0, 24'h001100));
    step(0, 0, 0, 24'h001200, "still_stop", mk(0, 0, 0, 4'd1, 3'd0, 24'h001200));

    // Clear from STOP: one-cycle cnt_clr, review ignored in empty IDLE
    step(0, 1, 0, 24'h001200, "clear", mk(0, 1, 0, 4'd0, 3'd0, 24'h001200));
    step(0, 0, 0, 24'h001200, "clr_drop", mk(0, 0, 0, 4'd0, 3'd0, 24'h001200));
    step(0, 0, 1, 24'h001200, "rv_empty", mk(0, 0, 0, 4'd0, 3'd0, 24'h001200));
    step(0, 1, 0, 24'h001200, "lr_idle", mk(0, 0, 0, 4'd0, 3'd0, 24'h001200));

    // Ten laps into an eight-entry buffer
    step(1, 0, 0, 24'h000000, "run3", mk(1, 0, 0, 4'd0, 3'd0, 24'h000000));
    lap_model.delete();
    for (int i = 1; i <= 10; i++) begin
      live = {8'h00, to_bcd(i), 8'h00};
      lap_model.push_back(live);
      if (lap_model.size() > DEPTH) void'(lap_model.pop_front());
      step(0, 1, 0, live, $sformatf("wrap_lap%0d", i),
           mk(1, 0, 0, 4'(lap_model.size()), 3'd0, live));
    end
    step(1, 0, 0, 24'h002000, "stop3", mk(0, 0, 0, 4'd8, 3'd0, 24'h002000));
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 1, 24'h002000, $sformatf("wrap_rev%0d", k),
           mk(0, 0, 1, 4'd8, 3'(k), lap_model[k]));
    end
    step(0, 0, 1, 24'h002000, "wrap_exit", mk(0, 0, 0, 4'd8, 3'd0, 24'h002000));

    // Asynchronous reset in the middle of a review
    step(0, 0, 1, 24'h002000, "rev_pre_rst", mk(0, 0, 1, 4'd8, 3'd0, lap_model[0]));
    step(0, 0, 1, 24'h002000, "rev_pre_rst1", mk(0, 0, 1, 4'd8, 3'd1, lap_model[1]));
    @(negedge clk_core);
    #2;
    rst = 1'b0;
    #1;
    chk_now("async_rst", mk(0, 0, 0, 4'd0, 3'd0, 24'h0));
    @(negedge clk_core);
    rst = 1'b1;
    step(0, 0, 1, 24'h003000, "post_rst_rv", mk(0, 0, 0, 4'd0, 3'd0, 24'h003000));
    step(1, 0, 0, 24'h003100, "post_rst_run", mk(1, 0, 0, 4'd0, 3'd0, 24'h003100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Sequencing controller for the stopwatch counter datapath. It turns single-cycle button pulses into enable and clear controls for the counter core, and captures lap times into a circular buffer. It also provides a review mode that steps through stored laps. It sits between the debounced button logic and the counter core/display mux, and drives the time shown on the display.

Parameters:
DEPTH, 8, number of lap entries held (power of two, 2..16)
IDX_W, 3, log2(DEPTH); width of index/pointer fields

Ports:
clk_core  in  1  system clock
rst  in  1  asynchronous active-low reset
start_stop  in  1  one-cycle pulse; run/stop toggle, also exits review
lap_rst  in  1  one-cycle pulse; lap capture when running, full clear when stopped
review  in  1  one-cycle pulse; enter review / step to next lap
min_i  in  8  live minutes from counter core, BCD
sec_i  in  8  live seconds, BCD
ms_10_i  in  8  live 10 ms units, BCD
cnt_en  out  1  counter core enable
cnt_clr  out  1  counter core synchronous clear, one-cycle pulse
min_o  out  8  displayed minutes
sec_o  out  8  displayed seconds
ms_10_o  out  8  displayed 10 ms units
lap_cnt  out  IDX_W+1  number of valid laps, 0..DEPTH
lap_idx  out  IDX_W  review index, 0 = oldest stored lap
reviewing  out  1  high while in REVIEW

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0. wr_ptr, lap_cnt and rd offset are 0. Buffer contents are don't-care.
- All outputs are registered. A pulse sampled at edge T takes effect on outputs after edge T (one-cycle latency).
- Priority when pulses coincide: start_stop > lap_rst > review. Lower-priority pulses in the same cycle are ignored.
- States: IDLE, RUN, STOP, REVIEW. A ret register remembers IDLE or STOP for returning from REVIEW.
- IDLE:
  - start_stop -> RUN.
  - review with lap_cnt>0 -> REVIEW, ret=IDLE, lap_idx=0.
  - review with lap_cnt=0 is ignored. lap_rst is ignored.
- RUN:
  - start_stop -> STOP.
  - lap_rst: write {min_i, sec_i, ms_10_i} sampled at that edge into buf[wr_ptr]. wr_ptr increments modulo DEPTH. lap_cnt saturates at DEPTH. When full, the oldest entry is overwritten.
  - review is ignored.
- STOP:
  - start_stop -> RUN.
  - lap_rst -> IDLE. cnt_clr pulses high for exactly one cycle. lap_cnt=0, wr_ptr=0.
  - review with lap_cnt>0 -> REVIEW, ret=STOP, lap_idx=0.
- REVIEW:
  - review with lap_idx<lap_cnt-1: lap_idx increments.
  - review with lap_idx=lap_cnt-1: return to ret; lap_idx=0.
  - start_stop: return to ret immediately (no run toggle).
  - lap_rst is ignored.
- Physical read address:
  - (wr_ptr + lap_idx) mod DEPTH when lap_cnt=DEPTH.
  - lap_idx otherwise.
- cnt_en=1 exactly while state=RUN. It is 0 in all other states, including REVIEW.
- reviewing=1 exactly while state=REVIEW.
- Display:
  - IDLE/RUN/STOP: min_o/sec_o/ms_10_o = live inputs registered (one-cycle delay).
  - REVIEW: outputs = the buffer entry at the read address, registered. They update the cycle after each step.
- Values are stored and passed through unmodified; no BCD arithmetic is performed.
- Reset asserted mid-operation (any state, including mid-review or at the cnt_clr cycle) forces the full reset values immediately. A cnt_clr pulse in progress is truncated.

Test Plan:
- Reset then start_stop, hold inputs at 01:23.45 -> cnt_en=1 one cycle after the pulse; min_o/sec_o/ms_10_o = 8'h01/8'h23/8'h45 one cycle after the inputs.
- RUN, lap_rst at times 00:01.00, 00:02.50, 00:03.75; stop; review x3 -> display shows 00:01.00, 00:02.50, 00:03.75 with lap_idx 0,1,2. The fourth review returns to STOP with reviewing=0.
- RUN, lap_rst 10 times (DEPTH=8) with sec_i=1..10 -> lap_cnt=8; review order shows sec 3..10 (oldest entries 1 and 2 overwritten).
- STOP with 3 laps, lap_rst -> cnt_clr high exactly 1 cycle; state IDLE, lap_cnt=0; a following review is ignored (reviewing stays 0).
- Simultaneous start_stop+lap_rst in RUN -> goes to STOP, no lap stored (lap_cnt unchanged). start_stop+review in STOP -> goes to RUN, no review.
- In REVIEW (ret=STOP), pulse start_stop -> back to STOP, cnt_en stays 0. Assert rst low mid-review -> all outputs 0 asynchronously, state IDLE after release.
